// File: rtl/stream_argmin.sv
// stream_argmin: sequential argmin over a valid/ready sample stream.
// Each frame yields its minimum value, the index of the first occurrence of that
// minimum, and the number of samples accepted. The result is held on out_* until
// it is accepted. A frame that reaches MAX_LEN beats without in_last is cut off
// there and reported with overflow set.
module stream_argmin #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_LEN);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               load_out;
    logic               ovf_set;
    logic               beat;

    // in_ready comes only from the registered state, so it has no combinational path from out_ready.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid & in_ready;

    // Next-state and running min/index/count update; decides when the result is loaded.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        min_d    = min_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        load_out = 1'b0;
        ovf_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    min_d = in_data;
                    idx_d = '0;
                    cnt_d = (IDX_W + 1)'(1);
                    if (in_last) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    // Strict less-than: an equal value never replaces the stored one, so the earliest index is kept.
                    if (in_data < min_q) begin
                        min_d = in_data;
                        idx_d = cnt_q[IDX_W-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (in_last || (cnt_d == MAX_CNT)) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                        ovf_set  = !in_last;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, running accumulators, and result registers that are loaded only when HOLD is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            min_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            out_min   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples the pre-edge values.
            state_q <= state_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (load_out) begin
                out_min   <= min_d;
                out_idx   <= idx_d;
                out_count <= cnt_d;
                overflow  <= ovf_set;
            end else if (beat && (state_q == IDLE)) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
